cache_mem_arbiter: RTL and testbench

//  Shares one external-memory command/data port between N_PORTS cache controllers (e.g. I$ and D$).

---
 rtl/cache_mem_arbiter_if.sv | 41 ++++
 rtl/cache_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Cache-controller / external-memory handshake bundle shared by the arbiter and its users.
// The slave modport is the arbiter's view; the master modport is the caches + memory side.
interface cache_mem_arbiter_if #(
  parameter int N_PORTS      = 2,
  parameter int BW_WORD_ADDR = 30
);
  logic [N_PORTS-1:0]              req_i;
  logic [N_PORTS-1:0]              req_block_i;
  logic [N_PORTS-1:0]              rw_i;
  logic [N_PORTS*BW_WORD_ADDR-1:0] addr_i;
  logic [N_PORTS-1:0]              ready_o;
  logic [N_PORTS-1:0]              rd_valid_o;
  logic [31:0]                     rd_data_o;
  logic [N_PORTS-1:0]              wr_valid_i;
  logic [N_PORTS*32-1:0]           wr_data_i;
  logic [N_PORTS-1:0]              wr_ack_o;
  logic                            mem_ready_i;
  logic                            mem_req_o;
  logic                            mem_req_block_o;
  logic                            mem_rw_o;
  logic [BW_WORD_ADDR-1:0]         mem_addr_o;
  logic                            mem_rd_valid_i;
  logic [31:0]                     mem_rd_data_i;
  logic                            mem_wr_valid_o;
  logic [31:0]                     mem_wr_data_o;
  logic                            mem_wr_ack_i;

  modport slave (
    input  req_i, req_block_i, rw_i, addr_i, wr_valid_i, wr_data_i,
    input  mem_ready_i, mem_rd_valid_i, mem_rd_data_i, mem_wr_ack_i,
    output ready_o, rd_valid_o, rd_data_o, wr_ack_o,
    output mem_req_o, mem_req_block_o, mem_rw_o, mem_addr_o, mem_wr_valid_o, mem_wr_data_o
  );

  modport master (
    output req_i, req_block_i, rw_i, addr_i, wr_valid_i, wr_data_i,
    output mem_ready_i, mem_rd_valid_i, mem_rd_data_i, mem_wr_ack_i,
    input  ready_o, rd_valid_o, rd_data_o, wr_ack_o,
    input  mem_req_o, mem_req_block_o, mem_rw_o, mem_addr_o, mem_wr_valid_o, mem_wr_data_o
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one external-memory port between N_PORTS cache controllers.
// Latches one command per port, issues the winner downstream and steers its data until done.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no transfer outstanding; pick next pending port when memory ready
//   ST_READ  | read transfer in flight; memory read words routed to grant_q
//   ST_WRITE | write transfer in flight; grant_q's write words routed to memory
module cache_mem_arbiter #(
  parameter int N_PORTS      = 2,
  parameter int BW_PORTS     = 1,
  parameter int BW_WORD_ADDR = 30,
  parameter int BW_BLOCK     = 4
) (
  input logic                clock_i,
  input logic                resetn_i,
  cache_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;

  state_t                  state_q, state_d;
  logic [N_PORTS-1:0]      pend_q, pend_d;
  logic [N_PORTS-1:0]      blk_q, blk_d;
  logic [N_PORTS-1:0]      rw_q, rw_d;
  logic [BW_WORD_ADDR-1:0] addr_q [N_PORTS];
  logic [BW_WORD_ADDR-1:0] addr_d [N_PORTS];
  logic [BW_PORTS-1:0]     grant_q, grant_d;
  logic [BW_PORTS-1:0]     last_grant_q, last_grant_d;
  logic [BW_BLOCK:0]       cnt_q, cnt_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_blk_q, mem_blk_d;
  logic                    mem_rw_q, mem_rw_d;
  logic [BW_WORD_ADDR-1:0] mem_addr_q, mem_addr_d;

  logic [BW_PORTS-1:0]     pick;
  logic [BW_PORTS-1:0]     rr_idx;
  logic                    pick_vld;
  logic [BW_BLOCK:0]       last_word;
  logic [N_PORTS-1:0]      rd_valid_c;
  logic [31:0]             rd_data_c;
  logic [N_PORTS-1:0]      wr_ack_c;
  logic                    mem_wr_valid_c;
  logic [31:0]             mem_wr_data_c;

  // Scan offsets from farthest to nearest so the first pending port after last_grant wins.
  always_comb begin
    pick     = last_grant_q;
    pick_vld = 1'b0;
    rr_idx   = '0;
    for (int i = N_PORTS; i >= 1; i--) begin
      rr_idx = BW_PORTS'((int'(last_grant_q) + i) % N_PORTS);
      if (pend_q[rr_idx]) begin
        pick_vld = 1'b1;
        pick     = rr_idx;
      end
    end
  end

  // The transfer length follows the block flag of the command currently issued.
  assign last_word = mem_blk_q ? {1'b0, {BW_BLOCK{1'b1}}} : '0;

  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q;
    blk_d          = blk_q;
    rw_d           = rw_q;
    addr_d         = addr_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    mem_req_d      = 1'b0;
    mem_blk_d      = mem_blk_q;
    mem_rw_d       = mem_rw_q;
    mem_addr_d     = mem_addr_q;
    rd_valid_c     = '0;
    rd_data_c      = '0;
    wr_ack_c       = '0;
    mem_wr_valid_c = 1'b0;
    mem_wr_data_c  = '0;

    for (int k = 0; k < N_PORTS; k++) begin
      if (bus.req_i[k] && !pend_q[k]) begin
        pend_d[k] = 1'b1;
        blk_d[k]  = bus.req_block_i[k];
        rw_d[k]   = bus.rw_i[k];
        addr_d[k] = bus.addr_i[k*BW_WORD_ADDR +: BW_WORD_ADDR];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.mem_ready_i && pick_vld) begin
          pend_d[pick] = 1'b0;
          mem_req_d    = 1'b1;
          mem_blk_d    = blk_q[pick];
          mem_rw_d     = rw_q[pick];
          mem_addr_d   = addr_q[pick];
          grant_d      = pick;
          last_grant_d = pick;
          cnt_d        = '0;
          state_d      = rw_q[pick] ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        rd_data_c           = bus.mem_rd_data_i;
        rd_valid_c[grant_q] = bus.mem_rd_valid_i;
        if (bus.mem_rd_valid_i) begin
          if (cnt_q == last_word) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        mem_wr_valid_c    = bus.wr_valid_i[grant_q];
        mem_wr_data_c     = bus.wr_data_i[32*int'(grant_q) +: 32];
        wr_ack_c[grant_q] = bus.mem_wr_ack_i;
        if (bus.mem_wr_ack_i) begin
          if (cnt_q == last_word) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      blk_q        <= '0;
      rw_q         <= '0;
      for (int k = 0; k < N_PORTS; k++) addr_q[k] <= '0;
      grant_q      <= '0;
      last_grant_q <= BW_PORTS'(N_PORTS - 1);
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_blk_q    <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      blk_q        <= blk_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_blk_q    <= mem_blk_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign bus.ready_o         = ~pend_q;
  assign bus.rd_valid_o      = rd_valid_c;
  assign bus.rd_data_o       = rd_data_c;
  assign bus.wr_ack_o        = wr_ack_c;
  assign bus.mem_req_o       = mem_req_q;
  assign bus.mem_req_block_o = mem_blk_q;
  assign bus.mem_rw_o        = mem_rw_q;
  assign bus.mem_addr_o      = mem_addr_q;
  assign bus.mem_wr_valid_o  = mem_wr_valid_c;
  assign bus.mem_wr_data_o   = mem_wr_data_c;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed commands push expected memory commands
// and per-word data into queues; a monitor pops and compares whenever the DUT presents them.
module tb_cache_mem_arbiter;
  localparam int N_PORTS      = 2;
  localparam int BW_PORTS     = 1;
  localparam int BW_WORD_ADDR = 30;
  localparam int BW_BLOCK     = 4;
  localparam int BLK          = 16;

  logic clock_i  = 1'b0;
  logic resetn_i = 1'b0;

  cache_mem_arbiter_if #(.N_PORTS(N_PORTS), .BW_WORD_ADDR(BW_WORD_ADDR)) bus ();

  cache_mem_arbiter #(
    .N_PORTS(N_PORTS), .BW_PORTS(BW_PORTS), .BW_WORD_ADDR(BW_WORD_ADDR), .BW_BLOCK(BW_BLOCK)
  ) dut (
    .clock_i (clock_i),
    .resetn_i(resetn_i),
    .bus     (bus)
  );

  always #5 clock_i = ~clock_i;

  int checks   = 0;
  int failures = 0;
  int rd_seen  = 0;
  int wr_seen  = 0;

  logic [31:0] exp_cmd [$];
  logic [33:0] exp_rd  [$];
  logic [33:0] exp_wr  [$];

  // memory model state
  int          m_left        = 0;
  int          m_idx         = 0;
  int          m_wstall      = 0;
  int          wr_stall_init = 0;
  logic        m_rd          = 1'b0;
  logic [29:0] m_base        = '0;

  function automatic logic [31:0] rd_word(input logic [29:0] a, input int i);
    return 32'hA500_0000 ^ {a[23:0], 8'h00} ^ 32'(i);
  endfunction

  function automatic logic [31:0] wr_word(input int k, input int i);
    return 32'hC0DE_0000 | 32'(k << 8) | 32'(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h required nothing", name, act);
  endtask

  // Monitor / scoreboard
  logic [31:0] e_cmd;
  logic [33:0] e_dat;
  initial begin
    forever begin
      @(negedge clock_i);
      if (resetn_i) begin
        if (bus.mem_req_o) begin
          if (exp_cmd.size() == 0) flag("cmd_unexpected", 64'({bus.mem_req_block_o, bus.mem_rw_o, bus.mem_addr_o}));
          else begin
            e_cmd = exp_cmd.pop_front();
            check("mem_cmd", 64'({bus.mem_req_block_o, bus.mem_rw_o, bus.mem_addr_o}), 64'(e_cmd));
          end
        end
        if (bus.rd_valid_o != '0) begin
          rd_seen++;
          if (exp_rd.size() == 0) flag("rd_unexpected", 64'({bus.rd_valid_o, bus.rd_data_o}));
          else begin
            e_dat = exp_rd.pop_front();
            check("rd_word", 64'({bus.rd_valid_o, bus.rd_data_o}), 64'(e_dat));
          end
        end
        if (bus.wr_ack_o != '0) begin
          wr_seen++;
          if (exp_wr.size() == 0) flag("wr_unexpected", 64'({bus.wr_ack_o, bus.mem_wr_data_o}));
          else begin
            e_dat = exp_wr.pop_front();
            check("wr_word", 64'({bus.wr_ack_o, bus.mem_wr_data_o}), 64'(e_dat));
          end
        end
        if (m_left > 0 && !m_rd)
          check("wr_valid_vs_stall", 64'(bus.mem_wr_valid_o), 64'(m_wstall == 0));
      end
    end
  end

  // Memory + write-data source model; drives its inputs 2 units after the clock edge.
  initial begin
    bus.mem_rd_valid_i = 1'b0;
    bus.mem_rd_data_i  = '0;
    bus.mem_wr_ack_i   = 1'b0;
    bus.wr_valid_i     = '0;
    bus.wr_data_i      = '0;
    forever begin
      @(posedge clock_i);
      if (m_left > 0) begin
        if (m_rd ? bus.mem_rd_valid_i : bus.mem_wr_ack_i) begin
          m_idx++;
          m_left--;
        end else if (!m_rd && m_wstall > 0) begin
          m_wstall--;
        end
      end
      #2;
      if (!resetn_i) begin
        m_left = 0;
      end else if (bus.mem_req_o) begin
        if (m_left > 0) flag("overlapping_issue", 64'(m_left));
        m_left   = bus.mem_req_block_o ? BLK : 1;
        m_rd     = !bus.mem_rw_o;
        m_base   = bus.mem_addr_o;
        m_idx    = 0;
        m_wstall = m_rd ? 0 : wr_stall_init;
      end
      bus.mem_rd_valid_i = (m_left > 0) && m_rd;
      bus.mem_rd_data_i  = ((m_left > 0) && m_rd) ? rd_word(m_base, m_idx) : 32'h0;
      bus.wr_valid_i     = ((m_left > 0) && !m_rd && m_wstall == 0) ? '1 : '0;
      for (int k = 0; k < N_PORTS; k++) bus.wr_data_i[k*32 +: 32] = wr_word(k, m_idx);
      bus.mem_wr_ack_i   = (m_left > 0) && !m_rd && (m_wstall == 0);
    end
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic push_read(input int k, input logic blk, input logic [29:0] a);
    exp_cmd.push_back({blk, 1'b0, a});
    for (int i = 0; i < (blk ? BLK : 1); i++) exp_rd.push_back({2'(1 << k), rd_word(a, i)});
  endtask

  task automatic push_write(input int k, input logic blk, input logic [29:0] a);
    exp_cmd.push_back({blk, 1'b1, a});
    for (int i = 0; i < (blk ? BLK : 1); i++) exp_wr.push_back({2'(1 << k), wr_word(k, i)});
  endtask

  task automatic issue(input logic [1:0] mask, input logic [1:0] blk, input logic [1:0] rw,
                       input logic [29:0] a0, input logic [29:0] a1);
    tick();
    bus.req_i       = mask;
    bus.req_block_i = blk;
    bus.rw_i        = rw;
    bus.addr_i      = {a1, a0};
    tick();
    bus.req_i = '0;
    @(negedge clock_i);
    check("ready_low_after_latch", 64'(bus.ready_o & mask), 64'(0));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_cmd.size() != 0 || exp_rd.size() != 0 || exp_wr.size() != 0 || m_left != 0) && n < budget) begin
      @(posedge clock_i);
      n++;
    end
    check("drain_in_budget", 64'(n < budget), 64'(1));
    if (n >= budget) begin
      exp_cmd.delete();
      exp_rd.delete();
      exp_wr.delete();
    end
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ready"},    64'(bus.ready_o), 64'(2'b11));
    check({tag, "_mem_cmd"},  64'({bus.mem_req_o, bus.mem_req_block_o, bus.mem_rw_o, bus.mem_addr_o}), 64'(0));
    check({tag, "_port_out"}, 64'({bus.rd_valid_o, bus.wr_ack_o, bus.rd_data_o}), 64'(0));
    check({tag, "_mem_wr"},   64'({bus.mem_wr_valid_o, bus.mem_wr_data_o}), 64'(0));
  endtask

  initial begin
    int base, n, s0, s1;
    logic [1:0]  req;
    logic [29:0] a0, a1;
    bus.req_i       = '0;
    bus.req_block_i = '0;
    bus.rw_i        = '0;
    bus.addr_i      = '0;
    bus.mem_ready_i = 1'b1;
    a0 = '0;
    a1 = '0;

    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    reset_checks("por");
    tick();
    resetn_i = 1'b1;

    // Reset in the middle of a block read
    push_read(0, 1'b1, 30'h400);
    issue(2'b01, 2'b01, 2'b00, 30'h400, 30'h0);
    base = rd_seen;
    n = 0;
    while (rd_seen < base + 5 && n < 100) begin
      @(posedge clock_i);
      n++;
    end
    check("t1_words_before_reset", 64'(rd_seen - base), 64'(5));
    #1;
    resetn_i = 1'b0;
    exp_rd.delete();
    exp_cmd.delete();
    @(negedge clock_i);
    reset_checks("t1_mid_reset");
    repeat (2) @(posedge clock_i);
    #1;
    resetn_i = 1'b1;
    repeat (20) @(posedge clock_i);
    check("t1_no_rd_after_reset", 64'(rd_seen - base), 64'(5));

    // Contention right after reset: last_grant is port 1, so port 0 goes first
    push_read(0, 1'b1, 30'h0A0);
    push_read(1, 1'b1, 30'h1B0);
    issue(2'b11, 2'b11, 2'b00, 30'h0A0, 30'h1B0);
    drain(200);
    check("t3_ready_after", 64'(bus.ready_o), 64'(2'b11));

    // Fairness: both ports keep re-requesting single-word reads
    push_read(0, 1'b0, 30'h800);
    push_read(1, 1'b0, 30'h810);
    push_read(0, 1'b0, 30'h801);
    push_read(1, 1'b0, 30'h811);
    s0 = 0;
    s1 = 0;
    n  = 0;
    while ((s0 < 2 || s1 < 2) && n < 100) begin
      tick();
      req = '0;
      if (bus.ready_o[0] && s0 < 2) begin req[0] = 1'b1; a0 = 30'h800 + 30'(s0); s0++; end
      if (bus.ready_o[1] && s1 < 2) begin req[1] = 1'b1; a1 = 30'h810 + 30'(s1); s1++; end
      bus.req_i       = req;
      bus.req_block_i = '0;
      bus.rw_i        = '0;
      bus.addr_i      = {a1, a0};
      n++;
    end
    tick();
    bus.req_i = '0;
    drain(100);

    // Single-port block read
    base = rd_seen;
    push_read(0, 1'b1, 30'h100);
    issue(2'b01, 2'b01, 2'b00, 30'h100, 30'h0);
    drain(100);
    check("t2_word_count", 64'(rd_seen - base), 64'(16));
    check("t2_ready_back", 64'(bus.ready_o), 64'(2'b11));

    // Block write from port 1 with write data stalled for 3 cycles
    base = wr_seen;
    wr_stall_init = 3;
    push_write(1, 1'b1, 30'h2A0);
    issue(2'b10, 2'b10, 2'b10, 30'h0, 30'h2A0);
    drain(200);
    wr_stall_init = 0;
    check("t5_ack_count", 64'(wr_seen - base), 64'(16));

    // Memory not ready for 10 cycles with port 0 pending, then single-word read
    base = rd_seen;
    tick();
    bus.mem_ready_i = 1'b0;
    issue(2'b01, 2'b00, 2'b00, 30'h03C, 30'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock_i);
      check("t6_pend_held", 64'(bus.ready_o), 64'(2'b10));
    end
    push_read(0, 1'b0, 30'h03C);
    tick();
    bus.mem_ready_i = 1'b1;
    drain(50);
    check("t6_word_count", 64'(rd_seen - base), 64'(1));

    repeat (5) @(posedge clock_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
